core_mem_stage: RTL

CORE_MEM_STAGE -- requirements
Module: core_mem_stage

---
 rtl/core_mem_stage.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/core_mem_stage.sv
// core_mem_stage: pipeline MEM stage with a request/grant/rvalid data-memory port.
// Handles byte/half/word loads and stores, flags misaligned accesses,
// stalls upstream while a memory access is pending, and registers MEM/WB results.
module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic            wb_reg_write_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misaligned_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] ST_IDLE        = 2'b00;
    localparam logic [1:0] ST_WAIT_GNT    = 2'b01;
    localparam logic [1:0] ST_WAIT_RVALID = 2'b10;

    // Access size is funct3[1:0]: 0 byte, 1 halfword, otherwise word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Sub-word store data is replicated into every lane; the byte enables pick the lane.
    function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] wd;
        case (size)
            2'b00:   wd = {(XLEN/8){data[7:0]}};
            2'b01:   wd = {(XLEN/16){data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Move the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] res;
        shifted = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  res = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  res = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  res = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic [1:0]      state_r, state_n;
    logic [1:0]      ld_off_r;
    logic [2:0]      ld_funct3_r;
    logic [4:0]      ld_rd_r;
    logic            ld_reg_write_r;
    logic            wb_valid_r, wb_valid_n;
    logic [4:0]      wb_rd_r, wb_rd_n;
    logic            wb_reg_write_r, wb_reg_write_n;
    logic [XLEN-1:0] wb_data_r, wb_data_n;
    logic            misaligned_r, misaligned_n;

    logic [1:0]      addr_off_s;
    logic            is_load_s;
    logic            is_store_s;
    logic            is_mem_s;
    logic            mis_s;
    logic            mem_ok_s;
    logic            req_s;
    logic            stall_s;
    logic            latch_ld_s;
    logic            we_s;
    logic [3:0]      be_s;
    logic [XLEN-1:0] addr_s;
    logic [XLEN-1:0] wdata_s;

    // Decode the EX/MEM instruction into memory-op class and alignment.
    always_comb begin
        addr_off_s = alu_result_i[1:0];
        is_load_s  = valid_i && (opcode_i == OP_LOAD);
        is_store_s = valid_i && (opcode_i == OP_STORE);
        is_mem_s   = is_load_s || is_store_s;
        mis_s      = is_misaligned(funct3_i[1:0], addr_off_s);
        mem_ok_s   = is_mem_s && !mis_s;
    end

    // Next-state, memory request, stall and MEM/WB next values.
    always_comb begin
        state_n        = state_r;
        req_s          = 1'b0;
        we_s           = 1'b0;
        be_s           = 4'b0000;
        addr_s         = {XLEN{1'b0}};
        wdata_s        = {XLEN{1'b0}};
        stall_s        = 1'b0;
        latch_ld_s     = 1'b0;
        wb_valid_n     = 1'b0;
        wb_rd_n        = wb_rd_r;
        wb_reg_write_n = 1'b0;
        wb_data_n      = wb_data_r;
        misaligned_n   = 1'b0;

        case (state_r)
            ST_IDLE, ST_WAIT_GNT: begin
                if (mem_ok_s) begin
                    // Upstream is frozen while stalled, so driving the bus from the
                    // EX/MEM inputs keeps it stable throughout WAIT_GNT.
                    req_s   = 1'b1;
                    we_s    = is_store_s;
                    addr_s  = {alu_result_i[XLEN-1:2], 2'b00};
                    if (is_store_s) begin
                        be_s    = store_be(funct3_i[1:0], addr_off_s);
                        wdata_s = store_wdata(funct3_i[1:0], rs2_data_i);
                    end else begin
                        be_s    = 4'b1111;
                        wdata_s = {XLEN{1'b0}};
                    end
                    if (dmem_gnt_i) begin
                        if (is_store_s) begin
                            state_n        = ST_IDLE;
                            wb_valid_n     = 1'b1;
                            wb_rd_n        = rd_i;
                            wb_reg_write_n = 1'b0;
                            wb_data_n      = alu_result_i;
                        end else begin
                            // Any rvalid in the grant cycle is not ours yet.
                            state_n    = ST_WAIT_RVALID;
                            latch_ld_s = 1'b1;
                            stall_s    = 1'b1;
                        end
                    end else begin
                        state_n = ST_WAIT_GNT;
                        stall_s = 1'b1;
                    end
                end else if (valid_i && (state_r == ST_IDLE)) begin
                    // Non-memory op, or a misaligned access that is dropped.
                    state_n    = ST_IDLE;
                    wb_valid_n = 1'b1;
                    wb_rd_n    = rd_i;
                    wb_data_n  = alu_result_i;
                    if (is_mem_s) begin
                        misaligned_n   = 1'b1;
                        wb_reg_write_n = 1'b0;
                    end else begin
                        misaligned_n   = 1'b0;
                        wb_reg_write_n = reg_write_i;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT_RVALID: begin
                if (dmem_rvalid_i) begin
                    state_n        = ST_IDLE;
                    wb_valid_n     = 1'b1;
                    wb_rd_n        = ld_rd_r;
                    wb_reg_write_n = ld_reg_write_r;
                    wb_data_n      = load_extract(ld_funct3_r, ld_off_r, dmem_rdata_i);
                end else begin
                    state_n = ST_WAIT_RVALID;
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Capture load context at grant so the response can be aligned and extended.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_off_r       <= 2'b00;
            ld_funct3_r    <= 3'b000;
            ld_rd_r        <= 5'd0;
            ld_reg_write_r <= 1'b0;
        end else if (latch_ld_s) begin
            ld_off_r       <= addr_off_s;
            ld_funct3_r    <= funct3_i;
            ld_rd_r        <= rd_i;
            ld_reg_write_r <= reg_write_i;
        end else begin
            ld_off_r       <= ld_off_r;
            ld_funct3_r    <= ld_funct3_r;
            ld_rd_r        <= ld_rd_r;
            ld_reg_write_r <= ld_reg_write_r;
        end
    end

    // MEM/WB output registers and the misaligned pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_r     <= 1'b0;
            wb_rd_r        <= 5'd0;
            wb_reg_write_r <= 1'b0;
            wb_data_r      <= {XLEN{1'b0}};
            misaligned_r   <= 1'b0;
        end else begin
            wb_valid_r     <= wb_valid_n;
            wb_rd_r        <= wb_rd_n;
            wb_reg_write_r <= wb_reg_write_n;
            wb_data_r      <= wb_data_n;
            misaligned_r   <= misaligned_n;
        end
    end

    // Request and stall are combinational; both are held low while in reset.
    always_comb begin
        dmem_req_o     = req_s && rst_ni;
        stall_o        = stall_s && rst_ni;
        dmem_we_o      = we_s;
        dmem_be_o      = be_s;
        dmem_addr_o    = addr_s;
        dmem_wdata_o   = wdata_s;
        wb_valid_o     = wb_valid_r;
        wb_rd_o        = wb_rd_r;
        wb_reg_write_o = wb_reg_write_r;
        wb_data_o      = wb_data_r;
        misaligned_o   = misaligned_r;
    end

endmodule
